// File: rtl/prm_sched_pkg.sv
// Shared types and sizing helpers for the PRM edge-mask scheduler slice.
package prm_sched_pkg;

  localparam int OBS_W_DEF = 15;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLEAR    = 3'd1,
    WAIT_OBS = 3'd2,
    SWEEP    = 3'd3,
    DONE     = 3'd4
  } sched_state_e;

  // Address/count width that never collapses to zero bits for tiny parameters.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prm_edge_mask_scheduler_if.sv
// Obstacle-code stream (valid/ready) between the voxel source and the scheduler.
interface prm_edge_mask_scheduler_if
  import prm_sched_pkg::*;
#(
  parameter int OBS_W = OBS_W_DEF
);

  logic             obs_valid;
  logic             obs_ready;
  logic [OBS_W-1:0] obs_data;
  logic             obs_last;

  modport master (
    output obs_valid,
    output obs_data,
    output obs_last,
    input  obs_ready
  );

  modport slave (
    input  obs_valid,
    input  obs_data,
    input  obs_last,
    output obs_ready
  );

endinterface

// File: rtl/prm_popcount.sv
// Combinational population count of a LANES-wide vector.
module prm_popcount
  import prm_sched_pkg::*;
#(
  parameter int W  = 32,
  parameter int PW = clog2_min1(W + 1)
) (
  input  logic [W-1:0]  bits,
  output logic [PW-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + PW'(bits[i]);
    end
  end

endmodule

// File: rtl/prm_edge_mask_scheduler.sv
// Streams obstacle codes through a time-multiplexed checker bank and OR-accumulates
// a per-edge blocked bitmap for the roadmap.
module prm_edge_mask_scheduler
  import prm_sched_pkg::*;
#(
  parameter int NUM_EDGES = 1024,
  parameter int LANES     = 32,
  parameter int OBS_W     = OBS_W_DEF,
  localparam int GROUPS   = NUM_EDGES / LANES,
  localparam int GW       = clog2_min1(GROUPS),
  localparam int CW       = clog2_min1(NUM_EDGES + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  prm_edge_mask_scheduler_if.slave obs,
  output logic [OBS_W-1:0]         chk_obs,
  output logic [GW-1:0]            chk_grp,
  input  logic [LANES-1:0]         chk_mask,
  output logic                     busy,
  output logic                     done,
  input  logic [GW-1:0]            rd_grp,
  output logic [LANES-1:0]         rd_mask,
  output logic [CW-1:0]            blocked_cnt
);

  localparam int PW = clog2_min1(LANES + 1);

  sched_state_e     state_reg, state_next;
  logic [OBS_W-1:0] chk_obs_reg;
  logic [GW-1:0]    chk_grp_reg;
  logic             last_reg;
  logic [CW-1:0]    blocked_cnt_reg;
  logic [LANES-1:0] rd_mask_reg;
  logic [LANES-1:0] map_row [GROUPS];

  logic             ready_comb;
  logic             busy_comb;
  logic             done_comb;
  logic             accept;
  logic             grp_last;
  logic             sweep_en;
  logic             clear_en;
  logic [LANES-1:0] cur_map;
  logic [LANES-1:0] new_bits;
  logic [PW-1:0]    new_cnt;

  assign accept   = obs.obs_valid && (state_reg == WAIT_OBS);
  assign grp_last = (chk_grp_reg == GW'(GROUPS - 1));
  assign sweep_en = (state_reg == SWEEP);
  assign clear_en = (state_reg == CLEAR);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (start) state_next = CLEAR;
      CLEAR:    state_next = WAIT_OBS;
      WAIT_OBS: if (obs.obs_valid) state_next = SWEEP;
      SWEEP:    if (grp_last) state_next = last_reg ? DONE : WAIT_OBS;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // FSM: outputs, decoded from the registered state only
  always_comb begin
    ready_comb = 1'b0;
    busy_comb  = 1'b1;
    done_comb  = 1'b0;
    case (state_reg)
      IDLE:     busy_comb  = 1'b0;
      WAIT_OBS: ready_comb = 1'b1;
      DONE:     done_comb  = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_obs_reg <= '0;
      chk_grp_reg <= '0;
      last_reg    <= 1'b0;
    end else if (accept) begin
      chk_obs_reg <= obs.obs_data;
      chk_grp_reg <= '0;
      last_reg    <= obs.obs_last;
    end else if (sweep_en) begin
      chk_grp_reg <= grp_last ? '0 : chk_grp_reg + GW'(1);
    end
  end

  // Only bits not already set in this group contribute to the blocked count.
  assign cur_map  = map_row[chk_grp_reg];
  assign new_bits = chk_mask & ~cur_map;

  prm_popcount #(
    .W  (LANES),
    .PW (PW)
  ) u_popcount (
    .bits  (new_bits),
    .count (new_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blocked_cnt_reg <= '0;
    end else if (clear_en) begin
      blocked_cnt_reg <= '0;
    end else if (sweep_en) begin
      blocked_cnt_reg <= blocked_cnt_reg + CW'(new_cnt);
    end
  end

  // Bitmap rows live in flops so CLEAR can wipe the whole map in one cycle.
  for (genvar gi = 0; gi < GROUPS; gi++) begin : g_map
    logic [LANES-1:0] row_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        row_reg <= '0;
      end else if (clear_en) begin
        row_reg <= '0;
      end else if (sweep_en && (chk_grp_reg == GW'(gi))) begin
        row_reg <= row_reg | chk_mask;
      end
    end

    assign map_row[gi] = row_reg;
  end

  // Registered read sees the pre-update row when it collides with a sweep write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_mask_reg <= '0;
    end else begin
      rd_mask_reg <= map_row[rd_grp];
    end
  end

  assign obs.obs_ready = ready_comb;
  assign busy          = busy_comb;
  assign done          = done_comb;
  assign chk_obs       = chk_obs_reg;
  assign chk_grp       = chk_grp_reg;
  assign rd_mask       = rd_mask_reg;
  assign blocked_cnt   = blocked_cnt_reg;

endmodule

// File: tb/tb_prm_edge_mask_scheduler.sv
// Scoreboard bench: a behavioural checker bank drives chk_mask, expected counts and rows are queued as stimulus is issued.
module tb_prm_edge_mask_scheduler;

  localparam int OBS_W  = 15;
  localparam int LANES  = 32;
  localparam int GROUPS = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [OBS_W-1:0]  chk_obs;
  logic [4:0]        chk_grp;
  logic [LANES-1:0]  chk_mask;
  logic              busy;
  logic              done;
  logic [4:0]        rd_grp = '0;
  logic [LANES-1:0]  rd_mask;
  logic [10:0]       blocked_cnt;

  prm_edge_mask_scheduler_if #(.OBS_W(OBS_W)) obs_if ();

  prm_edge_mask_scheduler #(
    .NUM_EDGES (1024),
    .LANES     (LANES),
    .OBS_W     (OBS_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .obs         (obs_if),
    .chk_obs     (chk_obs),
    .chk_grp     (chk_grp),
    .chk_mask    (chk_mask),
    .busy        (busy),
    .done        (done),
    .rd_grp      (rd_grp),
    .rd_mask     (rd_mask),
    .blocked_cnt (blocked_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural checker bank: which edges each obstacle code blocks, per group.
  function automatic logic [31:0] model_mask(input logic [OBS_W-1:0] code, input int g);
    logic [31:0] m;
    m = '0;
    case (code)
      15'h4000: if (g == 3) m = 32'h0000_0020;
      15'h0002: if (g == 0) m = 32'h0000_000F;
      15'h0004: if (g == 0) m = 32'h0000_003C;
      15'h0008: begin
        if (g == 7)  m = 32'hFFFF_0000;
        if (g == 20) m = 32'h0000_FFFF;
      end
      15'h0010: begin
        if (g == 7)  m = 32'h0001_0001;
        if (g == 31) m = 32'h8000_0001;
      end
      15'h0020: m = 32'h1 << g;
      15'h0040: m = 32'hFFFF_FFFF;
      default:  m = '0;
    endcase
    return m;
  endfunction

  assign chk_mask = model_mask(chk_obs, int'(chk_grp));

  int          n_checks = 0;
  int          n_pass   = 0;
  int          acc_cnt  = 0;
  int          exp_cnt  = 0;
  logic [31:0] exp_map [GROUPS];
  int          exp_q [$];
  logic [31:0] rd_q [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (obs_if.obs_valid && obs_if.obs_ready) acc_cnt++;
  end

  task automatic model_clear();
    for (int g = 0; g < GROUPS; g++) exp_map[g] = '0;
    exp_cnt = 0;
  endtask

  task automatic model_apply(input logic [OBS_W-1:0] code);
    logic [31:0] m;
    for (int g = 0; g < GROUPS; g++) begin
      m = model_mask(code, g);
      exp_cnt += $countones(m & ~exp_map[g]);
      exp_map[g] = exp_map[g] | m;
    end
  endtask

  task automatic start_set();
    model_clear();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_code(input logic [OBS_W-1:0] code, input bit last, input bit hold);
    bit ok;
    obs_if.obs_valid = 1'b1;
    obs_if.obs_data  = code;
    obs_if.obs_last  = last;
    model_apply(code);
    if (last) exp_q.push_back(exp_cnt);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (obs_if.obs_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    if (!ok) check_val("accept_timeout", obs_if.obs_ready, 1);
    if (!hold) obs_if.obs_valid = 1'b0;
    $display("obs code=0x%04h last=%0d accepted=%0d", code, last, ok);
  endtask

  task automatic wait_done(input int n0, input int exp_cycles, input bit chk_cycles);
    int n;
    bit seen;
    n = n0;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      check_val("done_timeout", done, 1);
    end else begin
      $display("done after %0d cycles blocked_cnt=%0d", n, blocked_cnt);
      if (chk_cycles) check_val("done_latency", n, exp_cycles);
      if (exp_q.size() == 0) check_val("scoreboard_empty", exp_q.size(), 1);
      else check_val("blocked_cnt", blocked_cnt, exp_q.pop_front());
      check_val("busy_in_done", busy, 1);
      @(posedge clk);
      #1;
      check_val("done_one_cycle", done, 0);
      check_val("busy_after_done", busy, 0);
    end
  endtask

  task automatic read_grp(input int g);
    @(negedge clk);
    rd_grp = 5'(g);
    rd_q.push_back(exp_map[g]);
    @(posedge clk);
    #1;
    check_val($sformatf("rd_mask[%0d]", g), rd_mask, rd_q.pop_front());
    $display("read grp=%0d rd_mask=0x%08h", g, rd_mask);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    int acc0;
    obs_if.obs_valid = 1'b0;
    obs_if.obs_data  = '0;
    obs_if.obs_last  = 1'b0;
    model_clear();

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_ready", obs_if.obs_ready, 0);
    check_val("rst_chk_obs", chk_obs, 0);
    check_val("rst_chk_grp", chk_grp, 0);
    check_val("rst_rd_mask", rd_mask, 0);
    check_val("rst_blocked", blocked_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: one all-clear code, latency 1+1+32+1
    start_set();
    fork
      send_code(15'h0001, 1'b1, 1'b0);
      wait_done(1, 35, 1'b1);
    join

    // 2: single edge in group 3
    start_set();
    fork
      send_code(15'h4000, 1'b1, 1'b0);
      wait_done(1, 35, 1'b1);
    join
    read_grp(3);
    read_grp(2);

    // 3: overlapping masks in group 0 are counted once
    start_set();
    fork
      begin
        send_code(15'h0002, 1'b0, 1'b0);
        send_code(15'h0004, 1'b1, 1'b0);
      end
      wait_done(1, 0, 1'b0);
    join
    read_grp(0);

    // 4: valid held through the sweep, second code accepted exactly once
    acc0 = acc_cnt;
    start_set();
    fork
      begin
        send_code(15'h0008, 1'b0, 1'b1);
        check_val("ready_in_sweep", obs_if.obs_ready, 0);
        send_code(15'h0010, 1'b1, 1'b0);
      end
      wait_done(1, 68, 1'b1);
    join
    check_val("accept_count", acc_cnt - acc0, 2);
    read_grp(7);
    read_grp(31);

    // 5: start while busy is ignored, next start clears
    start_set();
    fork
      send_code(15'h0020, 1'b1, 1'b0);
      begin
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      wait_done(1, 35, 1'b1);
    join
    read_grp(5);
    start_set();
    @(posedge clk);
    #1;
    check_val("clear_blocked", blocked_cnt, 0);
    check_val("clear_busy", busy, 1);
    read_grp(5);

    // 6: asynchronous reset in the middle of a sweep
    send_code(15'h0040, 1'b0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (chk_grp == 5'd10) found = 1'b1;
    end
    check_val("reached_grp10", chk_grp, 10);
    check_val("cnt_before_rst", blocked_cnt, 320);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_busy", busy, 0);
    check_val("arst_chk_grp", chk_grp, 0);
    check_val("arst_chk_obs", chk_obs, 0);
    check_val("arst_blocked", blocked_cnt, 0);
    check_val("arst_rd_mask", rd_mask, 0);
    check_val("arst_ready", obs_if.obs_ready, 0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("idle_after_rst", busy, 0);
    read_grp(10);
    read_grp(0);

    // normal operation resumes after reset
    start_set();
    fork
      send_code(15'h4000, 1'b1, 1'b0);
      wait_done(1, 35, 1'b1);
    join
    read_grp(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
